scan_chain_ctrl: RTL and testbench



---
 rtl/scan_pkg.sv | 14 +
 rtl/scan_shreg.sv | 40 ++++
 rtl/scan_chain_ctrl.sv | 159 +++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and defaults for the scan chain controller.
package scan_pkg;

   localparam int unsigned SCAN_CHAIN_LEN_DEF = 8;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      CAPTURE,
      UNLOAD,
      DONE
   } scan_state_t;

endpackage

// File: rtl/scan_shreg.sv
// Parallel-load, shift-left register with serial in and MSB serial out.
// Used both as the pattern PISO and as the response SIPO.
module scan_shreg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             shift,
   input  logic             sin,
   output logic [WIDTH-1:0] q,
   output logic             sout
);

   logic [WIDTH-1:0] q_q, q_d;

   // Next value: load wins over shift, otherwise hold.
   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = din;
      end else if (shift) begin
         q_d = {q_q[WIDTH-2:0], sin};
      end
   end

   // Register with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q    = q_q;
   assign sout = q_q[WIDTH-1];

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: shifts a pattern into a mux-based scan chain, issues
// one capture cycle, then unloads the captured response.
// Optional compare against an expected value: define SCAN_CMP_EN.
module scan_chain_ctrl
   import scan_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = SCAN_CHAIN_LEN_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CHAIN_LEN-1:0] pattern,
   input  logic [CHAIN_LEN-1:0] expected,
   output logic                 scan_en,
   output logic                 scan_in,
   input  logic                 scan_out,
   output logic                 busy,
   output logic                 done,
   output logic [CHAIN_LEN-1:0] response,
   output logic                 mismatch
);

   localparam int unsigned CNT_W = $clog2(CHAIN_LEN);
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(CHAIN_LEN - 1);

   scan_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic start_acc;
   logic cnt_last;
   logic pat_msb;
   logic [CHAIN_LEN-1:0] pat_bits_unused;
   logic resp_sout_unused;

   assign start_acc = (state_q == IDLE) && start;
   assign cnt_last  = (cnt_q == CntLast);

   // Next state and shift counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (cnt_last) begin
               state_d = CAPTURE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         CAPTURE: begin
            state_d = UNLOAD;
         end
         UNLOAD: begin
            if (cnt_last) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Moore output decode from registered state.
   always_comb begin
      scan_en = 1'b0;
      scan_in = 1'b0;
      busy    = (state_q != IDLE);
      done    = (state_q == DONE);
      unique case (state_q)
         SHIFT: begin
            scan_en = 1'b1;
            scan_in = pat_msb;
         end
         UNLOAD: begin
            scan_en = 1'b1;
         end
         default: ;
      endcase
   end

   // Pattern PISO: MSB leaves first so pattern[CHAIN_LEN-1] ends in the far cell.
   scan_shreg #(
      .WIDTH(CHAIN_LEN)
   ) u_pattern (
      .clk   (clk),
      .rst   (rst),
      .load  (start_acc),
      .din   (pattern),
      .shift (state_q == SHIFT),
      .sin   (1'b0),
      .q     (pat_bits_unused),
      .sout  (pat_msb)
   );

   // Response SIPO: cleared on start, fills from scan_out during UNLOAD.
   scan_shreg #(
      .WIDTH(CHAIN_LEN)
   ) u_response (
      .clk   (clk),
      .rst   (rst),
      .load  (start_acc),
      .din   ('0),
      .shift (state_q == UNLOAD),
      .sin   (scan_out),
      .q     (response),
      .sout  (resp_sout_unused)
   );

`ifdef SCAN_CMP_EN
   logic [CHAIN_LEN-1:0] expected_q;
   logic                 mismatch_q;

   // Expected is latched at start; compare uses the response value being written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         expected_q <= '0;
         mismatch_q <= 1'b0;
      end else if (start_acc) begin
         expected_q <= expected;
         mismatch_q <= 1'b0;
      end else if ((state_q == UNLOAD) && cnt_last) begin
         mismatch_q <= ({response[CHAIN_LEN-2:0], scan_out} != expected_q);
      end
   end

   assign mismatch = mismatch_q;
`else
   logic unused_expected;
   assign unused_expected = ^expected;
   assign mismatch        = 1'b0;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Self-checking bench for scan_chain_ctrl with a behavioural mux-scan chain.
module tb_scan_chain_ctrl;

   localparam int unsigned N = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [N-1:0] pattern = '0;
   logic [N-1:0] expected = '0;
   logic         scan_en;
   logic         scan_in;
   logic         scan_out;
   logic         busy;
   logic         done;
   logic [N-1:0] response;
   logic         mismatch;

   // Chain under test: cell 0 at scan_in end, functional data from the bench.
   logic [N-1:0] cells = '0;
   logic [N-1:0] func = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (scan_en) cells <= {cells[N-2:0], scan_in};
      else         cells <= func;
   end

   assign scan_out = cells[N-1];

   scan_chain_ctrl #(
      .CHAIN_LEN(N)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .pattern  (pattern),
      .expected (expected),
      .scan_en  (scan_en),
      .scan_in  (scan_in),
      .scan_out (scan_out),
      .busy     (busy),
      .done     (done),
      .response (response),
      .mismatch (mismatch)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_mismatch(input logic [N-1:0] fv, input logic [N-1:0] ev);
`ifdef SCAN_CMP_EN
      return fv != ev;
`else
      return 1'b0;
`endif
   endfunction

   // One full sequence, entered at #1 into an idle cycle. Cycle c counts from
   // the first cycle after the start edge.
   task automatic run_seq(input logic [N-1:0] pat, input logic [N-1:0] fv,
                          input logic [N-1:0] ev, input bit poke);
      logic exp_en, exp_in;
      pattern  = pat;
      expected = ev;
      func     = fv;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      // Inputs change after start; the controller must use the latched copies.
      pattern  = ~pat;
      expected = ~ev;
      for (int c = 1; c <= 2 * N + 2; c++) begin
         start  = 1'b0;
         exp_en = (c >= 1 && c <= N) || (c >= N + 2 && c <= 2 * N + 1);
         exp_in = (c >= 1 && c <= N) ? pat[N-c] : 1'b0;
         check("scan_en", 32'(scan_en), 32'(exp_en));
         check("scan_in", 32'(scan_in), 32'(exp_in));
         check("busy", 32'(busy), 32'd1);
         check("done", 32'(done), 32'(c == 2 * N + 2));
         if (c == N + 1) check("chain_loaded", 32'(cells), 32'(pat));
         if (c == 2 * N + 2) begin
            check("response", 32'(response), 32'(fv));
            check("mismatch_done", 32'(mismatch), 32'(model_mismatch(fv, ev)));
         end else begin
            check("mismatch_cleared", 32'(mismatch), 32'd0);
         end
         if (poke && c == 5) start = 1'b1;
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("resp_hold", 32'(response), 32'(fv));
      check("mm_hold", 32'(mismatch), 32'(model_mismatch(fv, ev)));
   endtask

   initial begin
      logic [N-1:0] rp, rf, re;

      // Reset state.
      @(posedge clk); #1;
      check("rst_scan_en", 32'(scan_en), 32'd0);
      check("rst_scan_in", 32'(scan_in), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_response", 32'(response), 32'd0);
      check("rst_mismatch", 32'(mismatch), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed load/capture, then back-to-back with an ignored mid-sequence start.
      run_seq(8'hA5, 8'h3C, 8'h3C, 1'b0);
      run_seq(8'hFF, 8'h00, 8'h00, 1'b1);
      run_seq(8'hA5, 8'h3C, 8'h3D, 1'b0);

      // Reset in the middle of UNLOAD.
      pattern = 8'h5A;
      func    = 8'h96;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      repeat (11) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      check("mid_rst_scan_en", 32'(scan_en), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_response", 32'(response), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_mismatch", 32'(mismatch), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_seq(8'hC3, 8'h69, 8'h69, 1'b0);

      // Randomized sequences.
      for (int i = 0; i < 12; i++) begin
         rp = N'($urandom);
         rf = N'($urandom);
         re = ($urandom_range(0, 1) == 0) ? rf : (rf ^ N'(1 << $urandom_range(0, N - 1)));
         run_seq(rp, rf, re, ($urandom_range(0, 1) == 1));
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
